// File: rtl/bp_pkg.sv
// Types and constants shared by the branch update controller and the BHT.
package bp_pkg;

    localparam int unsigned PcWDefault = 32;

    typedef struct packed {
        logic [PcWDefault-1:0] pc;
        logic                  pred;
    } bp_entry_t;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } bp_state_e;

    // 2-bit saturating counter encodings used by the BHT.
    localparam logic [1:0] CntStrongNt = 2'b00;
    localparam logic [1:0] CntWeakNt   = 2'b01;
    localparam logic [1:0] CntWeakT    = 2'b10;
    localparam logic [1:0] CntStrongT  = 2'b11;

endpackage

// File: rtl/bp_fifo.sv
// In-order synchronous FIFO with clear; push while full is accepted only with a same-cycle pop.
module bp_fifo
    import bp_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter type         entry_t = bp_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   clear_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] CntFull = (PtrW + 1)'(Depth);

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   cnt_q;
    entry_t          mem_q [Depth];
    logic            do_push, do_pop;

    always_comb begin
        full_o  = (cnt_q == CntFull);
        empty_o = (cnt_q == '0);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        head_o  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/branch_update_ctrl.sv
// Tracks in-flight predicted branches, trains the BHT and raises flush/redirect on mispredict.
// Optional performance counters are enabled with the BRU_PERF_CNT_EN macro.
module branch_update_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = PcWDefault
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_valid,
    input  logic [PC_W-1:0] fetch_pc,
    input  logic            predict_taken,
    output logic            fetch_ready,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    output logic [PC_W-1:0] update_pc,
    output logic            update_taken,
    output logic            update_enable,
    output logic            flush,
    output logic [PC_W-1:0] redirect_pc,
    output logic            sync_err
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispred
`endif
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
    } entry_t;

    bp_state_e       state_q, state_d;
    entry_t          head, push_entry;
    logic            full, empty;
    logic            ex_acc, hit, mis_now, push_en, pop_en;
    logic            upd_en_q, upd_taken_q, sync_err_q;
    logic [PC_W-1:0] upd_pc_q, redir_q;

    always_comb begin
        ex_acc     = ex_valid && (state_q == StRun);
        hit        = !empty && (head.pc == ex_pc);
        mis_now    = ex_acc && (!hit || (head.pred != ex_taken));
        pop_en     = ex_acc && !empty;
        // A full queue still takes a push when the head retires in the same cycle.
        push_en    = fetch_valid && (state_q == StRun) && (!full || pop_en) && !mis_now;
        push_entry = '{pc: fetch_pc, pred: predict_taken};
        state_d    = mis_now ? StFlush : StRun;
    end

    bp_fifo #(
        .Depth   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (mis_now),
        .push_i      (push_en),
        .push_data_i (push_entry),
        .pop_i       (pop_en),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            upd_en_q    <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
            redir_q     <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            upd_en_q <= ex_acc;
            if (ex_acc) begin
                upd_pc_q    <= ex_pc;
                upd_taken_q <= ex_taken;
            end
            if (mis_now) redir_q <= ex_taken ? ex_target : ex_pc + PC_W'(4);
            if (ex_acc && !hit) sync_err_q <= 1'b1;
        end
    end

    // Outputs are forced quiet for the whole time rst is held, not just after its first edge.
    always_comb begin
        fetch_ready   = !rst && (state_q == StRun) && !full;
        update_enable = !rst && upd_en_q;
        update_pc     = rst ? '0 : upd_pc_q;
        update_taken  = !rst && upd_taken_q;
        flush         = !rst && (state_q == StFlush);
        redirect_pc   = rst ? '0 : redir_q;
        sync_err      = !rst && sync_err_q;
    end

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_q, perf_mis_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            if (ex_acc && (perf_br_q != '1))   perf_br_q  <= perf_br_q + 32'd1;
            if (mis_now && (perf_mis_q != '1)) perf_mis_q <= perf_mis_q + 32'd1;
        end
    end

    assign perf_branches = rst ? '0 : perf_br_q;
    assign perf_mispred  = rst ? '0 : perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Directed vector bench for branch_update_ctrl (DEPTH=4, PC_W=32).
module tb_branch_update_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid, predict_taken, ex_valid, ex_taken;
    logic [31:0] fetch_pc, ex_pc, ex_target;
    logic        fetch_ready, update_taken, update_enable, flush, sync_err;
    logic [31:0] update_pc, redirect_pc;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches, perf_mispred;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_update_ctrl #(
        .DEPTH (4),
        .PC_W  (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .predict_taken (predict_taken),
        .fetch_ready   (fetch_ready),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .update_pc     (update_pc),
        .update_taken  (update_taken),
        .update_enable (update_enable),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .sync_err      (sync_err)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_branches (perf_branches),
        .perf_mispred  (perf_mispred)
`endif
    );

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        pred;
        logic        exv;
        logic [31:0] expc;
        logic        ext;
        logic [31:0] etg;
        logic        rdy;
        logic        ue;
        logic [31:0] upc;
        logic        ut;
        logic        fl;
        logic [31:0] rpc;
        logic        se;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic fv, logic [31:0] fpc, logic pred, logic exv,
                                logic [31:0] expc, logic ext, logic [31:0] etg, logic rdy,
                                logic ue, logic [31:0] upc, logic ut, logic fl,
                                logic [31:0] rpc, logic se);
        vec_t v;
        v = '{fv, fpc, pred, exv, expc, ext, etg, rdy, ue, upc, ut, fl, rpc, se};
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic chk_outs(int idx, logic rdy, logic ue, logic [31:0] upc, logic ut,
                            logic fl, logic [31:0] rpc, logic se);
        chk("fetch_ready", idx, 32'(fetch_ready), 32'(rdy));
        chk("update_enable", idx, 32'(update_enable), 32'(ue));
        chk("update_pc", idx, update_pc, upc);
        chk("update_taken", idx, 32'(update_taken), 32'(ut));
        chk("flush", idx, 32'(flush), 32'(fl));
        chk("redirect_pc", idx, redirect_pc, rpc);
        chk("sync_err", idx, 32'(sync_err), 32'(se));
    endtask

    task automatic drive(logic fv, logic [31:0] fpc, logic pred, logic exv,
                         logic [31:0] expc, logic ext, logic [31:0] etg);
        fetch_valid   = fv;
        fetch_pc      = fpc;
        predict_taken = pred;
        ex_valid      = exv;
        ex_pc         = expc;
        ex_taken      = ext;
        ex_target     = etg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // fv fpc pred | exv expc ext etg | rdy ue upc ut fl rpc se
        add(0, 0, 0, 0, 0, 0, 0,                                 1, 0, 32'h0, 0, 0, 32'h0, 0);
        add(1, 32'h100, 1, 0, 0, 0, 0,                           1, 0, 32'h0, 0, 0, 32'h0, 0);
        add(0, 0, 0, 1, 32'h100, 1, 32'h180,                     1, 1, 32'h100, 1, 0, 32'h0, 0);
        add(0, 0, 0, 0, 0, 0, 0,                                 1, 0, 32'h100, 1, 0, 32'h0, 0);
        add(1, 32'h200, 0, 0, 0, 0, 0,                           1, 0, 32'h100, 1, 0, 32'h0, 0);
        add(1, 32'h204, 1, 0, 0, 0, 0,                           1, 0, 32'h100, 1, 0, 32'h0, 0);
        // mispredict; the offered wrong-path push is dropped
        add(1, 32'h208, 0, 1, 32'h200, 1, 32'h400,               0, 1, 32'h200, 1, 1, 32'h400, 0);
        // EX resolution during FLUSH is ignored
        add(1, 32'h300, 1, 1, 32'h204, 1, 32'h500,               1, 0, 32'h200, 1, 0, 32'h400, 0);
        add(1, 32'h300, 1, 0, 0, 0, 0,                           1, 0, 32'h200, 1, 0, 32'h400, 0);
        add(1, 32'h304, 1, 0, 0, 0, 0,                           1, 0, 32'h200, 1, 0, 32'h400, 0);
        add(1, 32'h308, 1, 0, 0, 0, 0,                           1, 0, 32'h200, 1, 0, 32'h400, 0);
        add(1, 32'h30C, 1, 0, 0, 0, 0,                           0, 0, 32'h200, 1, 0, 32'h400, 0);
        // push while full with a same-cycle correct pop
        add(1, 32'h310, 1, 1, 32'h300, 1, 32'h900,               0, 1, 32'h300, 1, 0, 32'h400, 0);
        add(0, 0, 0, 1, 32'h304, 1, 32'h900,                     1, 1, 32'h304, 1, 0, 32'h400, 0);
        add(0, 0, 0, 1, 32'h308, 1, 32'h900,                     1, 1, 32'h308, 1, 0, 32'h400, 0);
        add(0, 0, 0, 1, 32'h30C, 1, 32'h900,                     1, 1, 32'h30C, 1, 0, 32'h400, 0);
        add(0, 0, 0, 1, 32'h310, 1, 32'h900,                     1, 1, 32'h310, 1, 0, 32'h400, 0);
        // resolution against an empty queue
        add(0, 0, 0, 1, 32'h500, 0, 32'h999,                     0, 1, 32'h500, 0, 1, 32'h504, 1);
        add(0, 0, 0, 0, 0, 0, 0,                                 1, 0, 32'h500, 0, 0, 32'h504, 1);
        add(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0,                     1, 0, 32'h500, 0, 0, 32'h504, 1);
        // fall-through redirect wraps to zero
        add(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h1234,              0, 1, 32'hFFFF_FFFC, 0, 1, 32'h0, 1);
        add(0, 0, 0, 0, 0, 0, 0,                                 1, 0, 32'hFFFF_FFFC, 0, 0, 32'h0, 1);

        rst = 1'b1;
        fetch_valid = 0; fetch_pc = 0; predict_taken = 0;
        ex_valid = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
        #1;
        chk_outs(-2, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_outs(-1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fv, vecs[i].fpc, vecs[i].pred, vecs[i].exv, vecs[i].expc,
                  vecs[i].ext, vecs[i].etg);
            chk_outs(i, vecs[i].rdy, vecs[i].ue, vecs[i].upc, vecs[i].ut, vecs[i].fl,
                     vecs[i].rpc, vecs[i].se);
        end

        // Reset asserted while in FLUSH with entries previously queued.
        drive(1, 32'h600, 1, 0, 0, 0, 0);
        drive(1, 32'h604, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h600, 0, 32'h700);
        chk_outs(100, 0, 1, 32'h600, 0, 1, 32'h604, 1);
        rst = 1'b1;
        #1;
        chk_outs(101, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_outs(102, 0, 0, 32'h0, 0, 0, 32'h0, 0);
`ifdef BRU_PERF_CNT_EN
        chk("perf_branches", 102, perf_branches, 32'h0);
        chk("perf_mispred", 102, perf_mispred, 32'h0);
`endif
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_outs(103, 1, 0, 32'h0, 0, 0, 32'h0, 0);
        // Queue must be empty after reset, so this resolution is a sync error.
        drive(0, 0, 0, 1, 32'h604, 1, 32'h800);
        chk_outs(104, 0, 1, 32'h604, 1, 1, 32'h800, 1);
`ifdef BRU_PERF_CNT_EN
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("perf_branches", 105, perf_branches, 32'h1);
        chk("perf_mispred", 105, perf_mispred, 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
